// File: rtl/zx_clk_pkg.sv
// -----------------------------------------------------------------------------
// zx_clk_pkg
// Shared constants and helpers for the Spectrum clock-enable generator.
//   level_w(levels)        : width of a level index (at least 1 bit).
//   level_mask(k, levels)  : CPU period mask of level k, (1 << (levels-k)) - 1.
//   level_half(k, levels)  : top set bit of that mask; this is the phase where
//                            the negative CPU strobe fires.
// -----------------------------------------------------------------------------
package zx_clk_pkg;

  localparam int TURBO_LEVELS_DEF = 5;
  localparam int CNT_W_DEF        = 6;
  localparam int PSG_LOG2_DEF     = 6;
  localparam int SETTLE_W_DEF     = 2;
  localparam int STALL_LEVEL_DEF  = 3;

  function automatic int level_w(input int levels);
    return (levels > 2) ? $clog2(levels) : 1;
  endfunction

  function automatic int level_mask(input int k, input int levels);
    int kk;
    // An out-of-range index maps to the fastest level, which keeps the shift
    // amount positive.
    kk = (k >= levels) ? levels - 1 : k;
    return (1 << (levels - kk)) - 1;
  endfunction

  function automatic int level_half(input int k, input int levels);
    int m;
    m = level_mask(k, levels);
    return m ^ (m >> 1);
  endfunction

endpackage

// File: rtl/zx_ce_gen_if.sv
// -----------------------------------------------------------------------------
// zx_ce_gen_if
// Bundle between the host top level (master) and the clock-enable generator
// (slave).
//   master drives : level_req, force_native, ram_ready, ext_p, ext_n
//   slave drives  : ce_28m, ce_7mp, ce_7mn, ce_psg, ce_cpu_p, ce_cpu_n,
//                   ce_cpu, cpu_en, level_cur, switching
// -----------------------------------------------------------------------------
interface zx_ce_gen_if
  import zx_clk_pkg::*;
#(
  parameter int LEVEL_W = level_w(TURBO_LEVELS_DEF)
);

  logic [LEVEL_W-1:0] level_req;
  logic               force_native;
  logic               ram_ready;
  logic               ext_p;
  logic               ext_n;

  logic               ce_28m;
  logic               ce_7mp;
  logic               ce_7mn;
  logic               ce_psg;
  logic               ce_cpu_p;
  logic               ce_cpu_n;
  logic               ce_cpu;
  logic               cpu_en;
  logic [LEVEL_W-1:0] level_cur;
  logic               switching;

  modport master (
    output level_req, force_native, ram_ready, ext_p, ext_n,
    input  ce_28m, ce_7mp, ce_7mn, ce_psg, ce_cpu_p, ce_cpu_n, ce_cpu,
           cpu_en, level_cur, switching
  );

  modport slave (
    input  level_req, force_native, ram_ready, ext_p, ext_n,
    output ce_28m, ce_7mp, ce_7mn, ce_psg, ce_cpu_p, ce_cpu_n, ce_cpu,
           cpu_en, level_cur, switching
  );

endinterface

// File: rtl/zx_ce_phase.sv
// -----------------------------------------------------------------------------
// zx_ce_phase
// Internal CPU phase strobes for the active turbo level.
//   clk_sys, reset_n : clock, async active-low reset
//   cnt              : master counter (pre-increment value)
//   level            : active level, selects period mask m and half-point h
//   tp               : registered (cnt & m) == 0
//   tn               : registered (cnt & m) == h
// -----------------------------------------------------------------------------
module zx_ce_phase
  import zx_clk_pkg::*;
#(
  parameter int TURBO_LEVELS = TURBO_LEVELS_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int LEVEL_W      = level_w(TURBO_LEVELS)
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [CNT_W-1:0]   cnt,
  input  logic [LEVEL_W-1:0] level,
  output logic               tp,
  output logic               tn
);

  logic [CNT_W-1:0] mask;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] phase;

  always_comb begin
    mask  = CNT_W'(level_mask(int'(level), TURBO_LEVELS));
    half  = CNT_W'(level_half(int'(level), TURBO_LEVELS));
    phase = cnt & mask;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tp <= 1'b0;
      tn <= 1'b0;
    end else begin
      tp <= (phase == '0);
      tn <= (phase == half);
    end
  end

endmodule

// File: rtl/zx_ce_gen.sv
// -----------------------------------------------------------------------------
// zx_ce_gen
// Clock-enable generator for the Spectrum host. A free-running counter on
// clk_sys yields fixed-rate video/PSG strobes and a CPU enable pair whose rate
// follows the active turbo level. Level changes are applied only on a CPU
// negative-phase strobe and are followed by a settle hold-off; fast levels
// stall while the SDRAM is not ready.
//   clk_sys, reset_n : system clock, async active-low reset
//   bus (slave)      : level request / overrides / ext strobes in,
//                      strobes, gated CPU enables and status out
// -----------------------------------------------------------------------------
module zx_ce_gen
  import zx_clk_pkg::*;
#(
  parameter int TURBO_LEVELS = TURBO_LEVELS_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int PSG_LOG2     = PSG_LOG2_DEF,
  parameter int SETTLE_W     = SETTLE_W_DEF,
  parameter int STALL_LEVEL  = STALL_LEVEL_DEF
) (
  input logic         clk_sys,
  input logic         reset_n,
  zx_ce_gen_if.slave  bus
);

  localparam int LW = level_w(TURBO_LEVELS);

  logic [CNT_W-1:0]    cnt;
  logic                ce_28m_q, ce_7mp_q, ce_7mn_q, ce_psg_q;
  logic                tp, tn;
  logic                sp, sn;
  logic [LW-1:0]       eff;

  logic                cpu_en_q, cpu_en_d;
  logic [LW-1:0]       level_q, level_d;
  logic [SETTLE_W-1:0] hold_q, hold_d;

  // ---------------------------------------------------------------------------
  // Master counter and fixed-rate strobes
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignments, so all strobes
  // are decoded from the same pre-increment cnt that the counter leaves behind.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      ce_28m_q <= 1'b0;
      ce_7mp_q <= 1'b0;
      ce_7mn_q <= 1'b0;
      ce_psg_q <= 1'b0;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      ce_28m_q <= (cnt[1:0] == 2'd0);
      ce_7mp_q <= !cnt[3] && (cnt[2:0] == 3'd0);
      ce_7mn_q <=  cnt[3] && (cnt[2:0] == 3'd0);
      ce_psg_q <= (cnt[PSG_LOG2-1:0] == '0);
    end
  end

  zx_ce_phase #(
    .TURBO_LEVELS (TURBO_LEVELS),
    .CNT_W        (CNT_W),
    .LEVEL_W      (LW)
  ) u_phase (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .cnt     (cnt),
    .level   (level_q),
    .tp      (tp),
    .tn      (tn)
  );

  // Native speed follows the contended-timing strobes from video.
  assign sp = (level_q == '0) ? bus.ext_p : tp;
  assign sn = (level_q == '0) ? bus.ext_n : tn;

  // ---------------------------------------------------------------------------
  // Effective request: tape forces native, oversized requests clamp.
  // ---------------------------------------------------------------------------
  always_comb begin
    eff = bus.level_req;
    if (int'(bus.level_req) >= TURBO_LEVELS) eff = LW'(TURBO_LEVELS - 1);
    if (bus.force_native)                    eff = '0;
  end

  // ---------------------------------------------------------------------------
  // Control: RUN (cpu_en), SETTLE (hold != 0), WAIT (neither). Changes are
  // only taken on a raw sn strobe so the CPU never sees a partial cycle; the
  // gated sp that follows is the first one under the new decision.
  // ---------------------------------------------------------------------------
  // NOTE: next-state defaults to the current state before any condition, so
  // every path assigns every signal and no latch is inferred.
  always_comb begin
    cpu_en_d = cpu_en_q;
    level_d  = level_q;
    hold_d   = hold_q;
    if (sn) begin
      // Hold-off counts up and wraps to 0, ending SETTLE.
      if (hold_q != '0) hold_d = hold_q + SETTLE_W'(1);
      if (eff != level_q) begin
        // Also taken mid-SETTLE: the hold-off restarts from the new change.
        cpu_en_d = 1'b0;
        level_d  = eff;
        hold_d   = SETTLE_W'(1);
      end else if (!cpu_en_q && (hold_q == '0) && bus.ram_ready) begin
        cpu_en_d = 1'b1;
      end else if ((int'(level_q) >= STALL_LEVEL) && !bus.ram_ready) begin
        cpu_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_en_q <= 1'b0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      cpu_en_q <= cpu_en_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ce_28m    = ce_28m_q;
  assign bus.ce_7mp    = ce_7mp_q;
  assign bus.ce_7mn    = ce_7mn_q;
  assign bus.ce_psg    = ce_psg_q;
  assign bus.ce_cpu_p  = cpu_en_q & sp;
  assign bus.ce_cpu_n  = cpu_en_q & sn;
  // FDC and tape always use the internal pair, never the contended strobes.
  assign bus.ce_cpu    = cpu_en_q & tp;
  assign bus.cpu_en    = cpu_en_q;
  assign bus.level_cur = level_q;
  assign bus.switching = (hold_q != '0);

endmodule

// File: doc/zx_ce_gen.md
# zx_ce_gen

Parametrised clock-enable generator for the Spectrum host. It replaces the fixed 5-level turbo divider and its inline enable logic in the top level. From a free-running master counter on `clk_sys` it derives the video/PSG strobes and the CPU `CEN_p`/`CEN_n` pair. It adds a configurable level count, a safe level-switch handshake with settle hold-off, SDRAM-ready stalling at fast levels, and a forced-native override.

## Interface
Parameters:
- `TURBO_LEVELS`, default 5: number of speed levels. Level k has CPU period mask `(1<<(TURBO_LEVELS-k))-1`. Level 0 is native speed (slowest); level `TURBO_LEVELS-1` uses mask 1.
- `CNT_W`, default 6: master counter width. Must be ≥ `TURBO_LEVELS` and ≥ `PSG_LOG2`.
- `PSG_LOG2`, default 6: `ce_psg` fires once per `2^PSG_LOG2` clocks.
- `SETTLE_W`, default 2: hold-off counter width. The CPU is held for `2^SETTLE_W - 1` raw `cpu_n` strobes after a level change.
- `STALL_LEVEL`, default 3: levels ≥ this value drop `cpu_en` while `ram_ready` = 0.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `level_req` in `$clog2(TURBO_LEVELS)`: requested level. Values ≥ `TURBO_LEVELS` clamp to `TURBO_LEVELS-1`.
- `force_native` in 1: overrides the request to level 0 (tape active).
- `ram_ready` in 1: SDRAM controller ready.
- `ext_p`, `ext_n` in 1: contended-timing strobes from video. Used instead of the internal pair at level 0.
- `ce_28m`, `ce_7mp`, `ce_7mn`, `ce_psg` out 1: fixed-rate strobes.
- `ce_cpu_p`, `ce_cpu_n` out 1: gated CPU enables.
- `ce_cpu` out 1: ungated-by-source positive phase, internal pair, gated by `cpu_en`. Used by FDC and tape.
- `cpu_en` out 1: CPU running.
- `level_cur` out `$clog2(TURBO_LEVELS)`: active level.
- `switching` out 1: hold-off in progress.

## Operation
- Master counter `cnt` increments every clock and wraps at `2^CNT_W`. All strobes are registered from the pre-increment `cnt`.
- `ce_28m` = `cnt[1:0]==0`.
- `ce_7mp` = `cnt[3]==0 && cnt[2:0]==0`.
- `ce_7mn` = `cnt[3]==1 && cnt[2:0]==0`.
- `ce_psg` = `cnt[PSG_LOG2-1:0]==0`.
- Internal phase strobes, with `m` = mask of `level_cur` and `h = m ^ (m>>1)` (top bit of `m`):
  - `tp` = `(cnt & m)==0`.
  - `tn` = `(cnt & m)==h`.
- Source pair: `sp/sn` = `ext_p/ext_n` when `level_cur==0`, else `tp/tn`.
- Gated outputs: `ce_cpu_p = cpu_en & sp`, `ce_cpu_n = cpu_en & sn`, `ce_cpu = cpu_en & tp`.
- Effective request `eff` = 0 if `force_native`, else clamped `level_req`.
- Control state updates only on clocks where raw `sn` = 1, in this priority order:
  1. If `hold != 0`, `hold` increments, wrapping to 0.
  2. If `eff != level_cur`: `cpu_en`←0, `level_cur`←`eff`, `hold`←1.
  3. Else if `!cpu_en && hold==0 && ram_ready`: `cpu_en`←1.
  4. Else if `level_cur >= STALL_LEVEL && !ram_ready`: `cpu_en`←0.
- States implied by `cpu_en`/`hold`:
  - RUN: `cpu_en`=1.
  - SETTLE: `hold`≠0.
  - WAIT: `cpu_en`=0, `hold`=0. Leaves on the first `sn` with `ram_ready`.
- A request change during SETTLE re-enters rule 2 and restarts `hold` at 1.
- `switching` = `hold != 0`.

## Timing
- Reset values: `cnt`=0, all strobes 0, `cpu_en`=0, `level_cur`=0, `hold`=0, `switching`=0.
- The first edge after `reset_n` rises registers strobes for `cnt`=0. At that edge `ce_28m`, `ce_7mp` and `ce_psg` all assert.
- Strobe latency is 1 clock from `cnt` value to output. Each strobe is a single-clock pulse.
- The enable decision is registered on the `sn` edge. The next gated `ce_cpu_p` follows at the next `sp`, so no partial CPU cycle is produced.
- A level change costs at least `2^SETTLE_W - 1` `sn` strobes of the new level plus one further `sn` for enable.
- Reset asserted mid-operation clears all state immediately, including during SETTLE.

## Structure
- Shared package `zx_clk_pkg`:
  - `LEVEL_W` function (`$clog2`).
  - `level_mask(k)` and `level_half(k)` functions.
  - Default parameter constants.
- Sub-module `zx_ce_phase`: combinational mask/half decode plus registered `tp`/`tn`.
- All other logic lives in `zx_ce_gen`.

## Test plan
- **Reset release, level 0, `ext_*` tied to internal:** `ce_28m` every 4 clocks, `ce_7mp` every 16 clocks, `ce_psg` every 64 clocks. `tp` period is 32 with `tn` 16 clocks after `tp`. `cpu_en`=1 after the first `sn` with `ram_ready`.
- **`level_req` 0→4 in RUN:** `cpu_en` falls at the next `sn` and `level_cur`=4. `switching` is high for 3 `sn` strobes (`sn` period 2). `cpu_en` rises on the 4th `sn`. `ce_cpu_p` then has period 2.
- **Level 4 with `ram_ready` low for 10 clocks:** `cpu_en` drops at the next `sn` and re-asserts at the first `sn` after `ram_ready` returns. At level 2 the same stimulus leaves `cpu_en` high.
- **`level_req`=7 (out of range):** clamps to `level_cur`=4. `force_native`=1 at level 4 returns to level 0 via SETTLE, and level 0 uses `ext_p`/`ext_n`.
- **Request changed 2→4 during SETTLE:** `hold` restarts at 1 and the full hold-off is counted from the second change.
- **`reset_n` low during SETTLE:** all outputs return to reset values asynchronously.
